// File: rtl/fft4_stream.sv
// Streaming 4-point complex DFT: loads four samples, computes both radix-4
// butterfly stages in one cycle, then drains X0..X3 over a valid/ready port.
module fft4_stream #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic                    inverse,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH+1:0] out_re,
  output logic signed [WIDTH+1:0] out_im,
  output logic [1:0]              out_idx,
  output logic                    out_last
);

  localparam int OW = WIDTH + 2;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [1:0]             cnt_q;
  logic [1:0]             idx_q;
  logic                   inv_q;
  logic signed [WIDTH-1:0] smp_re_q [4];
  logic signed [WIDTH-1:0] smp_im_q [4];
  logic signed [OW-1:0]   bin_re_q [4];
  logic signed [OW-1:0]   bin_im_q [4];

  logic signed [OW-1:0]   s0_re_d, s0_im_d, s1_re_d, s1_im_d;
  logic signed [OW-1:0]   d0_re_d, d0_im_d, d1_re_d, d1_im_d;
  logic signed [OW-1:0]   xm_re_d, xm_im_d, xp_re_d, xp_im_d;
  logic signed [OW-1:0]   x_re_d [4];
  logic signed [OW-1:0]   x_im_d [4];

  function automatic logic signed [OW-1:0] sx(input logic signed [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // Butterfly network; xm = D0 - j*D1, xp = D0 + j*D1.
  always_comb begin
    s0_re_d = sx(smp_re_q[0]) + sx(smp_re_q[2]);
    s0_im_d = sx(smp_im_q[0]) + sx(smp_im_q[2]);
    s1_re_d = sx(smp_re_q[1]) + sx(smp_re_q[3]);
    s1_im_d = sx(smp_im_q[1]) + sx(smp_im_q[3]);
    d0_re_d = sx(smp_re_q[0]) - sx(smp_re_q[2]);
    d0_im_d = sx(smp_im_q[0]) - sx(smp_im_q[2]);
    d1_re_d = sx(smp_re_q[1]) - sx(smp_re_q[3]);
    d1_im_d = sx(smp_im_q[1]) - sx(smp_im_q[3]);
    xm_re_d = d0_re_d + d1_im_d;
    xm_im_d = d0_im_d - d1_re_d;
    xp_re_d = d0_re_d - d1_im_d;
    xp_im_d = d0_im_d + d1_re_d;
    x_re_d[0] = s0_re_d + s1_re_d;
    x_im_d[0] = s0_im_d + s1_im_d;
    x_re_d[2] = s0_re_d - s1_re_d;
    x_im_d[2] = s0_im_d - s1_im_d;
    if (inv_q) begin
      x_re_d[1] = xp_re_d;
      x_im_d[1] = xp_im_d;
      x_re_d[3] = xm_re_d;
      x_im_d[3] = xm_im_d;
    end else begin
      x_re_d[1] = xm_re_d;
      x_im_d[1] = xm_im_d;
      x_re_d[3] = xp_re_d;
      x_im_d[3] = xp_im_d;
    end
  end

  // Frame controller: load four samples, compute, drain four bins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      inv_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        smp_re_q[i] <= '0;
        smp_im_q[i] <= '0;
        bin_re_q[i] <= '0;
        bin_im_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            smp_re_q[cnt_q] <= in_re;
            smp_im_q[cnt_q] <= in_im;
            if (cnt_q == 2'd0) begin
              inv_q <= inverse;
            end
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          for (int i = 0; i < 4; i++) begin
            bin_re_q[i] <= x_re_d[i];
            bin_im_q[i] <= x_im_d[i];
          end
          idx_q   <= 2'd0;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              cnt_q   <= 2'd0;
              state_q <= S_LOAD;
            end
          end
        end
        default: begin
          state_q <= S_LOAD;
          cnt_q   <= 2'd0;
          idx_q   <= 2'd0;
        end
      endcase
    end
  end

  // Reset gates in_ready directly so it is low for the whole reset pulse.
  assign in_ready  = (state_q == S_LOAD) && !rst;
  assign out_valid = (state_q == S_OUT);
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == 2'd3);
  assign out_re    = bin_re_q[idx_q];
  assign out_im    = bin_im_q[idx_q];

endmodule

// File: tb/tb_fft4_stream.sv
// Scoreboard bench for fft4_stream: directed frames push hand-computed bins,
// a negedge monitor pops and compares every output transfer.
module tb_fft4_stream;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_re = 32'sd0;
  logic signed [31:0] in_im = 32'sd0;
  logic               inverse = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [33:0] out_re;
  logic signed [33:0] out_im;
  logic [1:0]         out_idx;
  logic               out_last;

  fft4_stream #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .inverse(inverse),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint re;
    longint im;
    int     idx;
  } exp_t;

  exp_t   sb[$];
  int     v0_q[$];
  int     tests = 0;
  int     fails = 0;
  int     d_hs_cyc = 0;
  logic   prev_valid = 1'b0;

  logic signed [31:0] fr_re [4];
  logic signed [31:0] fr_im [4];
  logic               fr_inv [4];
  int                 fr_gap [4];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push4(input longint r0, input longint i0, input longint r1, input longint i1,
                       input longint r2, input longint i2, input longint r3, input longint i3);
    sb.push_back('{r0, i0, 0});
    sb.push_back('{r1, i1, 1});
    sb.push_back('{r2, i2, 2});
    sb.push_back('{r3, i3, 3});
  endtask

  task automatic set_frame(input logic signed [31:0] r0, input logic signed [31:0] i0,
                           input logic signed [31:0] r1, input logic signed [31:0] i1,
                           input logic signed [31:0] r2, input logic signed [31:0] i2,
                           input logic signed [31:0] r3, input logic signed [31:0] i3,
                           input logic inv);
    fr_re[0] = r0; fr_im[0] = i0;
    fr_re[1] = r1; fr_im[1] = i1;
    fr_re[2] = r2; fr_im[2] = i2;
    fr_re[3] = r3; fr_im[3] = i3;
    for (int k = 0; k < 4; k++) begin
      fr_inv[k] = inv;
      fr_gap[k] = 0;
    end
  endtask

  // Sends n samples of the staged frame; called from posedge+1.
  task automatic send_frame(input int n);
    bit ok;
    for (int s = 0; s < n; s++) begin
      if (fr_gap[s] > 0) begin
        in_valid = 1'b0;
        repeat (fr_gap[s]) begin @(posedge clk); #1; end
      end
      in_re = fr_re[s]; in_im = fr_im[s]; inverse = fr_inv[s]; in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          d_hs_cyc = cyc;
        end
        @(posedge clk); #1;
      end
      if (!ok) chk("in_handshake_timeout", 0, 1);
    end
    in_valid = 1'b0;
    inverse  = ~inverse;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && in_ready) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", longint'(sb.size()), 0);
  endtask

  // Monitor: compare each output transfer against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && !prev_valid && out_idx == 2'd0) v0_q.push_back(cyc);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("out_idx", longint'(out_idx), longint'(e.idx));
            chk("out_re", longint'(out_re), e.re);
            chk("out_im", longint'(out_im), e.im);
            chk("out_last", longint'(out_last), longint'(e.idx == 3));
          end
        end
        prev_valid = out_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    bit ok;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_out_re", longint'(out_re), 0);
    chk("rst_out_im", longint'(out_im), 0);
    chk("rst_out_idx", longint'(out_idx), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", longint'(in_ready), 1);
    @(posedge clk); #1;

    // Forward 1,2,3,4 with latency check
    v0_q.delete();
    set_frame(1, 0, 2, 0, 3, 0, 4, 0, 1'b0);
    push4(10, 0, -2, 2, -2, 0, -2, -2);
    send_frame(4);
    drain();
    chk("latency", (v0_q.size() > 0) ? longint'(v0_q[0] - d_hs_cyc) : -1, 2);

    // Inverse latched on A, toggled afterwards
    set_frame(1, 0, 2, 0, 3, 0, 4, 0, 1'b1);
    fr_inv[1] = 1'b0; fr_inv[2] = 1'b1; fr_inv[3] = 1'b0;
    push4(10, 0, -2, -2, -2, 0, -2, 2);
    send_frame(4);
    drain();

    // Most negative inputs
    set_frame(32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000,
              32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 1'b0);
    push4(-(64'sd1 <<< 33), -(64'sd1 <<< 33), 0, 0, 0, 0, 0, 0);
    send_frame(4);
    drain();

    // in_valid gaps plus 3-cycle stall on X1
    set_frame(1, 1, 0, 2, -3, 0, 5, -4, 1'b0);
    for (int k = 0; k < 4; k++) fr_gap[k] = $urandom_range(0, 3);
    fr_gap[1] = 2;
    push4(3, -1, 10, 6, -7, 3, -2, -4);
    send_frame(4);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (out_valid && out_idx == 2'd1) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("stall_reach_x1", longint'(ok), 1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", longint'(out_valid), 1);
      chk("stall_idx", longint'(out_idx), 1);
      chk("stall_re", longint'(out_re), 10);
      chk("stall_im", longint'(out_im), 6);
      chk("stall_in_ready", longint'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        chk("in_ready_after_x3", longint'(sb.size()), 0);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("in_ready_return", longint'(ok), 1);

    // Reset after B, then impulse 5
    set_frame(7, 7, 9, 9, 0, 0, 0, 0, 1'b0);
    send_frame(2);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", longint'(in_ready), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_frame(5, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    push4(5, 0, 5, 0, 5, 0, 5, 0);
    send_frame(4);
    drain();

    // Back-to-back frames, 9-cycle period
    v0_q.delete();
    set_frame(1, 0, 2, 0, 3, 0, 4, 0, 1'b0);
    push4(10, 0, -2, 2, -2, 0, -2, -2);
    send_frame(4);
    set_frame(0, 1, 0, 0, 0, 0, 0, 0, 1'b0);
    push4(0, 1, 0, 1, 0, 1, 0, 1);
    send_frame(4);
    drain();
    chk("b2b_period", (v0_q.size() > 1) ? longint'(v0_q[1] - v0_q[0]) : -1, 9);

    // Reset while bins are pending: none may appear
    out_ready = 1'b0;
    set_frame(1, 0, 2, 0, 3, 0, 4, 0, 1'b0);
    send_frame(4);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      if (out_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("outrst_reach_out", longint'(ok), 1);
    rst = 1'b1;
    #1;
    chk("outrst_out_valid", longint'(out_valid), 0);
    chk("outrst_out_last", longint'(out_last), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("outrst_no_bins", longint'(out_valid), 0);
    chk("sb_empty", longint'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft4_stream.md
# fft4_stream

Streaming, parametrised 4-point complex DFT engine with valid/ready handshakes on both sides. It takes four complex samples serially, computes the complete radix-4 result (both butterfly stages, including the ±j twiddle), and emits X0..X3 serially. A per-frame runtime inverse mode is included. Outputs are unscaled and widened by 2 bits, so no overflow is possible. It replaces the single-stage combinational butterfly in the transform datapath.

## Interface
- WIDTH, 32: signed two's-complement width of input real and imaginary parts.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_re  in  WIDTH  input sample, real part (signed).
- in_im  in  WIDTH  input sample, imaginary part (signed).
- inverse  in  1  mode select; sampled only with the first sample of a frame (0 = forward, 1 = inverse).
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts the bin.
- out_re  out  WIDTH+2  output bin, real part (signed).
- out_im  out  WIDTH+2  output bin, imaginary part (signed).
- out_idx  out  2  bin index k of the current output.
- out_last  out  1  high when out_idx == 3 and out_valid is high.

## Operation
- Frame: 4 consecutive accepted input samples, named A, B, C, D in order. Output is X0, X1, X2, X3 in order.
- Transfer rule: a transfer occurs on a rising edge where valid and ready are both high. There is no other way to transfer data.
- State machine:
  - LOAD: in_ready = 1. A 2-bit sample counter selects the buffer slot. When the 4th sample is accepted, go to CALC.
  - CALC: one cycle, in_ready = 0. Register all 4 results into the output buffer. Go to OUT.
  - OUT: out_valid = 1. Each output transfer increments out_idx. The transfer at out_idx 3 returns the machine to LOAD, with out_idx and the sample counter both cleared.
- Arithmetic: sign-extend all operands to WIDTH+2 bits before any add or subtract.
  - Intermediate terms: S0 = A+C, S1 = B+D, D0 = A−C, D1 = B−D.
  - X0 = S0+S1.
  - X2 = S0−S1.
  - Forward mode: X1 = D0 − j·D1, X3 = D0 + j·D1.
  - Multiplying by −j maps (re, im) to (im, −re). Multiplying by +j maps (re, im) to (−im, re).
  - Inverse mode swaps the X1 and X3 formulas. There is no 1/N scaling.
- The inverse bit is latched on acceptance of sample A and held for the whole frame. Changes to the inverse input during the rest of the frame are ignored.
- in_valid may drop between samples. The frame is still assembled correctly from the accepted samples only.
- in_ready is 0 in CALC and OUT. There is no overlap of load and drain.
- out_re, out_im and out_idx hold stable while out_valid = 1 and out_ready = 0.
- While rst is high: in_ready = 0 and out_valid = 0.

## Timing
- Reset values:
  - State: LOAD.
  - Sample counter: 0. out_idx: 0.
  - out_valid: 0. out_last: 0.
  - out_re and out_im: 0.
  - Input buffer and latched inverse bit: 0.
  - in_ready rises in the first cycle after rst deasserts.
- Latency: the edge that accepts D is edge T. The block is in CALC during cycle T+1. The first cycle with out_valid = 1 and out_idx = 0 is T+2.
- Throughput with no backpressure and continuous in_valid: 9 cycles per frame (4 load, 1 calc, 4 drain).
- After the transfer of X3 at edge U, in_ready = 1 in the cycle following U.
- Reset asserted mid-frame, in any state: the partial frame is discarded immediately. No output bins appear for it. Sample counting restarts at A after reset.
- Reset in OUT with out_valid high: out_valid drops asynchronously. The remaining bins are never emitted.
- Worst case, all inputs at −2^(WIDTH−1): X0 reaches −2^(WIDTH+1). This fits in WIDTH+2 bits, so no wrap occurs.

## Test plan
- Forward mode, real input A..D = 1, 2, 3, 4 (imaginary parts 0) -> X0 = 10+0j, X1 = −2+2j, X2 = −2+0j, X3 = −2−2j. out_idx runs 0..3 and out_last is high on X3 only. First out_valid occurs 2 cycles after D is accepted.
- Same data with inverse = 1 on A, and inverse toggled during B..D -> X1 = −2−2j, X3 = −2+2j. X0 and X2 are unchanged, showing the mode was latched on A.
- WIDTH = 32, all eight components at −2^31 -> X0 = (−2^33, −2^33) in 34 bits; X1, X2 and X3 are all 0.
- Random in_valid gaps plus out_ready held low 3 cycles on X1 -> X1 is held stable while stalled, all bins are correct, and in_ready stays 0 until X3 transfers.
- Reset asserted after B is accepted, then a full frame of 5, 0, 0, 0 is sent -> exactly one output frame, all four bins = 5+0j. No outputs from the aborted frame.
- Back-to-back frames with continuous valid/ready -> 9-cycle period, and the second frame's results are independent of the first.
